shift_data_feeder: RTL and testbench

- Memory-side producer for the shift data path; drives its write_en/data_in stream.
- Walks a word-packed greyscale image in raster order. For each centre row r and word column c it fetches three vertically adjacent words (rows r-1, r, r+1) over a req/ack memory read port, then pushes them one per cycle.
- Flags when the downstream 6-word window (2 columns x 3 rows, w0..w5) holds a complete, valid neighbourhood.

---
 rtl/edge_pkg.sv | 19 +
 rtl/shift_data_feeder_if.sv | 36 +++
 rtl/feeder_addr_gen.sv | 100 ++++++++++
 rtl/shift_data_feeder.sv | 168 ++++++++++++++++
 tb/tb_shift_data_feeder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the shift data feeder: FSM state encoding,
// word/column geometry and default parameter widths.
package edge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_PUSH,
        ST_ADV,
        ST_FIN
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORDS_PER_COL  = 3;
    localparam int ADDR_W_DEF     = 32;
    localparam int DIM_W_DEF      = 12;

endpackage

// File: rtl/shift_data_feeder_if.sv
// Memory read port plus push stream of the shift data feeder.
// Optional row_start strobe when SHIFT_FEEDER_ROW_MARK_EN is defined.
interface shift_data_feeder_if
    import edge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              write_en;
    logic [31:0]       data_in;
    logic              window_valid;
`ifdef SHIFT_FEEDER_ROW_MARK_EN
    logic              row_start;

    modport master (
        output mem_req, mem_addr, write_en, data_in, window_valid, row_start,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_addr, write_en, data_in, window_valid, row_start,
        output mem_ack, mem_rdata
    );
`else
    modport master (
        output mem_req, mem_addr, write_en, data_in, window_valid,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_addr, write_en, data_in, window_valid,
        output mem_ack, mem_rdata
    );
`endif
endinterface

// File: rtl/feeder_addr_gen.sv
// Row/column/word counters and incremental read address for the feeder.
// first_push output exists only when SHIFT_FEEDER_ROW_MARK_EN is defined.
module feeder_addr_gen
    import edge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              step_k,
    input  logic              next_col,
    input  logic              next_row,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  width_words,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] addr,
    output logic              k_last,
    output logic              c_zero,
    output logic              last_col,
    output logic              last_row
`ifdef SHIFT_FEEDER_ROW_MARK_EN
    ,
    output logic              first_push
`endif
);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BYTES_PER_WORD);
    localparam int                WORD_SHIFT = $clog2(BYTES_PER_WORD);

    logic [DIM_W-1:0]  r_q, r_d, c_q, c_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] stride_q, stride_d, row_base_q, row_base_d;
    logic [ADDR_W-1:0] col_addr_q, col_addr_d, addr_q, addr_d;

    // addr_q tracks row_base + c*4 + k*stride using only adds
    always_comb begin
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        col_addr_d = col_addr_q;
        addr_d     = addr_q;
        if (init) begin
            r_d        = DIM_W'(1);
            c_d        = '0;
            k_d        = '0;
            stride_d   = ADDR_W'(width_words) << WORD_SHIFT;
            row_base_d = base_addr;
            col_addr_d = base_addr;
            addr_d     = base_addr;
        end else if (step_k) begin
            k_d    = k_q + 2'd1;
            addr_d = addr_q + stride_q;
        end else if (next_col) begin
            c_d        = c_q + DIM_W'(1);
            k_d        = '0;
            col_addr_d = col_addr_q + WORD_BYTES;
            addr_d     = col_addr_q + WORD_BYTES;
        end else if (next_row) begin
            r_d        = r_q + DIM_W'(1);
            c_d        = '0;
            k_d        = '0;
            row_base_d = row_base_q + stride_q;
            col_addr_d = row_base_q + stride_q;
            addr_d     = row_base_q + stride_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            col_addr_q <= '0;
            addr_q     <= '0;
        end else begin
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            col_addr_q <= col_addr_d;
            addr_q     <= addr_d;
        end
    end

    assign addr     = addr_q;
    assign k_last   = (k_q == 2'(WORDS_PER_COL - 1));
    assign c_zero   = (c_q == '0);
    assign last_col = (c_q == width_words - DIM_W'(1));
    assign last_row = (r_q == height - DIM_W'(2));
`ifdef SHIFT_FEEDER_ROW_MARK_EN
    assign first_push = (k_q == '0) && (c_q == '0);
`endif

endmodule

// File: rtl/shift_data_feeder.sv
// Raster-order 3-row word fetcher feeding the shift data path.
// SHIFT_FEEDER_ROW_MARK_EN adds a row_start strobe on the first push of each centre row.
//
// state | meaning
// IDLE  | waiting for start, operands latched on start
// CHECK | reject degenerate frames, initialise counters
// REQ   | mem_req held until mem_ack, read word captured
// PUSH  | captured word driven with write_en
// ADV   | window_valid if c>=1, step column/row or finish
// FIN   | done pulse
module shift_data_feeder
    import edge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [DIM_W-1:0]    width_words,
    input  logic [DIM_W-1:0]    height,
    shift_data_feeder_if.master bus,
    output logic                busy,
    output logic                done
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
    logic [31:0]       data_q, data_d;
    logic              mem_req_q, mem_req_d, write_en_q, write_en_d;
    logic              window_valid_q, window_valid_d, busy_q, busy_d, done_q, done_d;
    logic              init, step_k, next_col, next_row;
    logic              k_last, c_zero, last_col, last_row;
    logic [ADDR_W-1:0] addr;
`ifdef SHIFT_FEEDER_ROW_MARK_EN
    logic              first_push, row_start_q, row_start_d;
`endif

    feeder_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .step_k     (step_k),
        .next_col   (next_col),
        .next_row   (next_row),
        .base_addr  (base_q),
        .width_words(width_q),
        .height     (height_q),
        .addr       (addr),
        .k_last     (k_last),
        .c_zero     (c_zero),
        .last_col   (last_col),
        .last_row   (last_row)
`ifdef SHIFT_FEEDER_ROW_MARK_EN
        ,
        .first_push (first_push)
`endif
    );

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        width_d        = width_q;
        height_d       = height_q;
        data_d         = data_q;
        write_en_d     = 1'b0;
        window_valid_d = 1'b0;
        init           = 1'b0;
        step_k         = 1'b0;
        next_col       = 1'b0;
        next_row       = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                base_d   = base_addr;
                width_d  = width_words;
                height_d = height;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (width_q == '0 || height_q < DIM_W'(WORDS_PER_COL)) begin
                    state_d = ST_FIN;
                end else begin
                    init    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: if (bus.mem_ack) begin
                data_d     = bus.mem_rdata;
                write_en_d = 1'b1;
                state_d    = ST_PUSH;
            end
            ST_PUSH: begin
                if (k_last) begin
                    window_valid_d = !c_zero;
                    state_d        = ST_ADV;
                end else begin
                    step_k  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_ADV: begin
                if (!last_col) begin
                    next_col = 1'b1;
                    state_d  = ST_REQ;
                end else if (!last_row) begin
                    next_row = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // outputs are registered images of the state being entered
        mem_req_d = (state_d == ST_REQ);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_FIN);
        done_d    = (state_d == ST_FIN);
`ifdef SHIFT_FEEDER_ROW_MARK_EN
        row_start_d = write_en_d && first_push;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            width_q        <= '0;
            height_q       <= '0;
            data_q         <= '0;
            mem_req_q      <= 1'b0;
            write_en_q     <= 1'b0;
            window_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef SHIFT_FEEDER_ROW_MARK_EN
            row_start_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            width_q        <= width_d;
            height_q       <= height_d;
            data_q         <= data_d;
            mem_req_q      <= mem_req_d;
            write_en_q     <= write_en_d;
            window_valid_q <= window_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef SHIFT_FEEDER_ROW_MARK_EN
            row_start_q    <= row_start_d;
`endif
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = addr;
    assign bus.write_en     = write_en_q;
    assign bus.data_in      = data_q;
    assign bus.window_valid = window_valid_q;
`ifdef SHIFT_FEEDER_ROW_MARK_EN
    assign bus.row_start    = row_start_q;
`endif
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_data_feeder.sv
// Self-checking bench for shift_data_feeder: table of frames plus reset and start corner cases.
module tb_shift_data_feeder;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] base_addr;
    logic [11:0] width_words, height;
    logic        busy, done;

    always #5 clk = ~clk;

    shift_data_feeder_if bus ();

    shift_data_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .width_words(width_words),
        .height     (height),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [31:0] base;
        int          w;
        int          h;
        int          maxd;
        bit          stray;
        bit          poke;
        int          exp_push;
        int          exp_wv;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    bit          resp_en = 1'b1, stray_en = 1'b0, manual_ack = 1'b0;
    logic [31:0] manual_rdata = '0;
    int          cur_maxd = 0, cur_w = 1, wait_cnt = 0, cur_delay = 0;
    bit          ack_prev = 1'b0, req_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    logic [31:0] addr_seen[$];
    logic [31:0] push_seen[$];
    int          n_push = 0, n_wv = 0, n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // monitor and memory responder share one process so ack/push ordering is race-free
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.write_en) begin
                push_seen.push_back(bus.data_in);
`ifdef SHIFT_FEEDER_ROW_MARK_EN
                check("row_start", 32'(bus.row_start),
                      32'((cur_w > 0) ? ((n_push % (3 * cur_w)) == 0) : 1'b0));
`endif
                n_push++;
            end
`ifdef SHIFT_FEEDER_ROW_MARK_EN
            else if (bus.row_start) check("row_start_idle", 32'(bus.row_start), 32'd0);
`endif
            if (bus.write_en || ack_prev)
                check("push_after_ack", 32'(bus.write_en), 32'(ack_prev));
            if (bus.window_valid) begin
                n_wv++;
                check("wv_pos", 32'((n_push > 0) && (n_push % 3 == 0) && (cur_w > 0) &&
                                    ((((n_push / 3) - 1) % cur_w) != 0)), 32'd1);
            end
            if (done) begin
                n_done++;
                check("done_busy", 32'(busy), 32'd0);
            end
            if (bus.mem_req) begin
                if (req_prev) check("addr_stable", bus.mem_addr, addr_prev);
                else addr_seen.push_back(bus.mem_addr);
            end
            req_prev  = bus.mem_req;
            addr_prev = bus.mem_addr;

            if (resp_en) begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req) begin
                    if (wait_cnt >= cur_delay) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mdata(bus.mem_addr);
                        wait_cnt      = 0;
                        cur_delay     = (cur_maxd > 0) ? int'($urandom_range(cur_maxd, 0)) : 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                    if (stray_en && ($urandom_range(3, 0) == 0)) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = 32'hDEAD_BEEF;
                    end
                end
            end else begin
                bus.mem_ack   = manual_ack;
                bus.mem_rdata = manual_rdata;
            end
            ack_prev = bus.mem_ack && bus.mem_req;
        end
    end

    task automatic clear_obs();
        addr_seen.delete();
        push_seen.delete();
        n_push = 0;
        n_wv   = 0;
        n_done = 0;
    endtask

    task automatic run_frame(input vec_t v);
        int          cyc;
        int          idx;
        bit          got;
        logic [31:0] ea;
        clear_obs();
        cur_w     = v.w;
        cur_maxd  = v.maxd;
        stray_en  = v.stray;
        wait_cnt  = 0;
        cur_delay = (v.maxd > 0) ? int'($urandom_range(v.maxd, 0)) : 0;
        @(negedge clk); #1;
        base_addr   = v.base;
        width_words = 12'(v.w);
        height      = 12'(v.h);
        start       = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            if (v.poke && cyc == 3) begin
                start       = 1'b1;
                base_addr   = 32'h0000_ABC0;
                width_words = 12'd1;
                height      = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        if (v.exp_push == 0) check("degen_latency", 32'(cyc <= 3), 32'd1);
        if (v.poke && got) begin
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check("fin_start_busy", 32'(busy), 32'd0);
                check("fin_start_req", 32'(bus.mem_req), 32'd0);
                @(negedge clk); #1;
            end
        end else begin
            repeat (2) @(negedge clk);
            #1;
        end
        stray_en = 1'b0;
        check("n_push", n_push, v.exp_push);
        check("n_wv", n_wv, v.exp_wv);
        check("n_done", n_done, 32'd1);
        check("n_req", addr_seen.size(), v.exp_push);
        idx = 0;
        for (int r = 1; r <= v.h - 2; r++)
            for (int c = 0; c < v.w; c++)
                for (int k = 0; k < 3; k++) begin
                    ea = v.base + 32'(c * 4) + 32'((r - 1 + k) * v.w * 4);
                    if (idx < addr_seen.size()) check("addr", addr_seen[idx], ea);
                    if (idx < push_seen.size()) check("data", push_seen[idx], mdata(ea));
                    idx++;
                end
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{32'h0000_0100, 2, 3, 0, 1'b0, 1'b0, 6, 1};
        vecs[1] = '{32'h0000_2000, 3, 4, 7, 1'b1, 1'b0, 18, 4};
        vecs[2] = '{32'h0000_0040, 1, 4, 1, 1'b0, 1'b0, 6, 0};
        vecs[3] = '{32'h0000_0300, 5, 2, 0, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{32'h0000_0300, 0, 5, 0, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{32'hFFFF_FFF8, 2, 3, 2, 1'b0, 1'b1, 6, 1};
        vecs[6] = '{32'h0000_1000, 4, 5, 7, 1'b1, 1'b1, 36, 9};
        vecs[7] = '{32'h0000_0500, 2, 4, 0, 1'b0, 1'b0, 12, 2};

        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        width_words = '0;
        height      = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_write_en", 32'(bus.write_en), 32'd0);
        check("rst_data_in", bus.data_in, 32'd0);
        check("rst_window_valid", 32'(bus.window_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i]);

        // reset while a request is outstanding, then an ack arrives
        resp_en = 1'b0;
        clear_obs();
        cur_w = 2;
        @(negedge clk); #1;
        base_addr   = 32'h0000_0700;
        width_words = 12'd2;
        height      = 12'd3;
        start       = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!bus.mem_req && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("mid_reach_req", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'd0);
        manual_ack   = 1'b1;
        manual_rdata = 32'hDEAD_0001;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        manual_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_rst_no_push", n_push, 32'd0);
        check("mid_rst_idle_busy", 32'(busy), 32'd0);
        resp_en = 1'b1;
        rv = '{32'h0000_0800, 2, 3, 0, 1'b0, 1'b0, 6, 1};
        run_frame(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
